// File: rtl/apb_cmd_master_if.sv
// apb_cmd_master_if: command/response stream plus APB master pins.
// APB_PREADY_EN adds pready and rsp_err.
interface apb_cmd_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_write;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_rdata;

  logic              busy;

  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;

`ifdef APB_PREADY_EN
  logic              pready;
  logic              rsp_err;

  modport master (
    input  cmd_valid, cmd_addr, cmd_write, cmd_wdata,
    input  rsp_ready, prdata, pready,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata,
    output busy, paddr, psel, penable, pwrite, pwdata,
    output rsp_err
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_write, cmd_wdata,
    output rsp_ready, prdata, pready,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata,
    input  busy, paddr, psel, penable, pwrite, pwdata,
    input  rsp_err
  );
`else
  modport master (
    input  cmd_valid, cmd_addr, cmd_write, cmd_wdata,
    input  rsp_ready, prdata,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata,
    output busy, paddr, psel, penable, pwrite, pwdata
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_write, cmd_wdata,
    output rsp_ready, prdata,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata,
    input  busy, paddr, psel, penable, pwrite, pwdata
  );
`endif

endinterface

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: command FIFO feeding an APB SETUP/ACCESS master.
// Optional APB_PREADY_EN: pready wait states with TIMEOUT abort.
module apb_cmd_master #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int CMD_DEPTH = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic             pclk,
  input  logic             preset,
  apb_cmd_master_if.master bus
);

  localparam int AW = $clog2(CMD_DEPTH);
  localparam int EW = ADDR_W + DATA_W + 1;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(CMD_DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0)
  begin : g_bad_depth
    $error("CMD_DEPTH must be a power of 2 and >= 2");
  end

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be >= 1");
  end

  // Command FIFO state
  logic [EW-1:0]     mem_q [CMD_DEPTH];
  logic [AW-1:0]     wr_q, wr_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [EW-1:0]     head;
  logic              head_write;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;

  // APB FSM and registered pins
  logic [1:0]        state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;

  // Response slot
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic              slot_free;
  logic              done;
  logic              rd_ok;
  logic [DATA_W-1:0] done_rdata;

  assign full  = (cnt_q == CNT_FULL);
  assign empty = (cnt_q == '0);
  assign push  = bus.cmd_valid && !full;

  assign head = mem_q[rd_q];
  assign {head_write, head_addr, head_wdata} = head;

  // A new transfer may only start if its response has somewhere to go.
  assign slot_free = !rsp_valid_q || bus.rsp_ready;
  assign pop = (state_q == S_IDLE) && !empty && slot_free;

`ifdef APB_PREADY_EN
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] WMAX = TW'(TIMEOUT - 1);

  logic [TW-1:0] wcnt_q, wcnt_d;
  logic          rsp_err_q, rsp_err_d;
  logic          tmo;

  assign tmo   = !bus.pready && (wcnt_q == WMAX);
  assign done  = (state_q == S_ACCESS) && (bus.pready || tmo);
  assign rd_ok = bus.pready;

  // Wait counter: cleared on SETUP entry, counts stalled ACCESS cycles.
  always_comb begin
    wcnt_d = wcnt_q;
    if (pop) begin
      wcnt_d = '0;
    end else if (state_q == S_ACCESS && !bus.pready && !tmo) begin
      wcnt_d = wcnt_q + 1'b1;
    end
  end

  // Error flag follows each completion; timeout is the only error.
  always_comb begin
    rsp_err_d = rsp_err_q;
    if (done) begin
      rsp_err_d = tmo;
    end
  end

  // Wait counter and error registers
  always_ff @(posedge pclk) begin
    if (preset) begin
      wcnt_q    <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      wcnt_q    <= wcnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign bus.rsp_err = rsp_err_q;
`else
  assign done  = (state_q == S_ACCESS);
  assign rd_ok = 1'b1;
`endif

  // Writes and timed-out reads return zero data.
  assign done_rdata = (pwrite_q || !rd_ok) ? '0 : bus.prdata;

  // FIFO pointer and occupancy next-state
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) begin
      wr_d = wr_q + 1'b1;
    end
    if (pop) begin
      rd_d = rd_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // APB sequencing: IDLE -> SETUP -> ACCESS -> IDLE
  always_comb begin
    state_d   = state_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d   = S_SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = head_write;
          paddr_d   = head_addr;
          pwdata_d  = head_wdata;
        end
      end
      S_SETUP: begin
        state_d   = S_ACCESS;
        penable_d = 1'b1;
      end
      S_ACCESS: begin
        if (done) begin
          state_d   = S_IDLE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
        end
      end
      default: begin
        state_d   = S_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  // Response slot: load on completion, else drain on handshake.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    if (done) begin
      rsp_valid_d = 1'b1;
      rsp_write_d = pwrite_q;
      rsp_rdata_d = done_rdata;
    end else if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // FIFO storage needs no reset; pointers define validity.
  always_ff @(posedge pclk) begin
    if (push) begin
      mem_q[wr_q] <= {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};
    end
  end

  // Control, APB and response registers
  always_ff @(posedge pclk) begin
    if (preset) begin
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      state_q     <= S_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.cmd_ready = !full;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_write = rsp_write_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.paddr     = paddr_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.busy      = (cnt_q != '0) || (state_q != S_IDLE)
                         || rsp_valid_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: directed bench for apb_cmd_master.
// Build with APB_PREADY_EN to also cover wait states and timeout.
module tb_apb_cmd_master;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  apb_cmd_master_if #(.ADDR_W(32), .DATA_W(32)) bif ();

  apb_cmd_master #(
    .ADDR_W(32),
    .DATA_W(32),
    .CMD_DEPTH(4),
    .TIMEOUT(16)
  ) dut (
    .pclk(clk),
    .preset(rst),
    .bus(bif)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (bif.psel !== 1'b0 || bif.penable !== 1'b0) begin
      failures++;
      $display("FAIL rst_apb psel=%b penable=%b exp=0,0",
               bif.psel, bif.penable);
    end
    checks++;
    if (bif.rsp_valid !== 1'b0 || bif.busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_rsp rsp_valid=%b busy=%b exp=0,0",
               bif.rsp_valid, bif.busy);
    end
    checks++;
    if (bif.paddr !== 32'h0 || bif.pwdata !== 32'h0
        || bif.rsp_rdata !== 32'h0 || bif.pwrite !== 1'b0
        || bif.rsp_write !== 1'b0) begin
      failures++;
      $display("FAIL rst_data paddr=%h pwdata=%h rdata=%h exp=0",
               bif.paddr, bif.pwdata, bif.rsp_rdata);
    end
`ifdef APB_PREADY_EN
    checks++;
    if (bif.rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL rst_err got=%b exp=0", bif.rsp_err);
    end
`endif
    rst = 1'b0;
    checks++;
    if (bif.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_cmd_ready got=%b exp=1", bif.cmd_ready);
    end
  endtask

  task automatic test_write();
    bif.rsp_ready = 1'b1;
    bif.cmd_valid = 1'b1;
    bif.cmd_addr  = 32'h10;
    bif.cmd_write = 1'b1;
    bif.cmd_wdata = 32'hDEADBEEF;
    tick();
    bif.cmd_valid = 1'b0;
    checks++;
    if (bif.psel !== 1'b0 || bif.busy !== 1'b1) begin
      failures++;
      $display("FAIL wr_e0 psel=%b busy=%b exp=0,1",
               bif.psel, bif.busy);
    end
    tick();
    checks++;
    if (bif.psel !== 1'b1 || bif.penable !== 1'b0) begin
      failures++;
      $display("FAIL wr_setup psel=%b penable=%b exp=1,0",
               bif.psel, bif.penable);
    end
    checks++;
    if (bif.paddr !== 32'h10 || bif.pwrite !== 1'b1
        || bif.pwdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL wr_bus paddr=%h pwrite=%b pwdata=%h exp=10,1,deadbeef",
               bif.paddr, bif.pwrite, bif.pwdata);
    end
    tick();
    checks++;
    if (bif.psel !== 1'b1 || bif.penable !== 1'b1) begin
      failures++;
      $display("FAIL wr_access psel=%b penable=%b exp=1,1",
               bif.psel, bif.penable);
    end
    tick();
    checks++;
    if (bif.rsp_valid !== 1'b1 || bif.rsp_write !== 1'b1
        || bif.rsp_rdata !== 32'h0 || bif.psel !== 1'b0
        || bif.penable !== 1'b0) begin
      failures++;
      $display("FAIL wr_rsp valid=%b write=%b rdata=%h psel=%b exp=1,1,0,0",
               bif.rsp_valid, bif.rsp_write, bif.rsp_rdata, bif.psel);
    end
    tick();
    checks++;
    if (bif.rsp_valid !== 1'b0 || bif.busy !== 1'b0) begin
      failures++;
      $display("FAIL wr_drain rsp_valid=%b busy=%b exp=0,0",
               bif.rsp_valid, bif.busy);
    end
  endtask

  task automatic test_read();
    bif.rsp_ready = 1'b1;
    bif.cmd_valid = 1'b1;
    bif.cmd_addr  = 32'h20;
    bif.cmd_write = 1'b0;
    bif.cmd_wdata = 32'hFFFFFFFF;
    tick();
    bif.cmd_valid = 1'b0;
    tick();
    checks++;
    if (bif.psel !== 1'b1 || bif.paddr !== 32'h20
        || bif.pwrite !== 1'b0) begin
      failures++;
      $display("FAIL rd_setup psel=%b paddr=%h pwrite=%b exp=1,20,0",
               bif.psel, bif.paddr, bif.pwrite);
    end
    bif.prdata = 32'h12345678;
    tick();
    tick();
    checks++;
    if (bif.rsp_valid !== 1'b1 || bif.rsp_write !== 1'b0
        || bif.rsp_rdata !== 32'h12345678) begin
      failures++;
      $display("FAIL rd_rsp valid=%b write=%b rdata=%h exp=1,0,12345678",
               bif.rsp_valid, bif.rsp_write, bif.rsp_rdata);
    end
    bif.prdata = 32'hBAD0BAD0;
    tick();
  endtask

  task automatic test_backpressure();
    bit [5:0]    exp_rdy = 6'b011111;
    int          setups;
    int          stall_psel;
    logic [31:0] ea;
    logic [31:0] er;
    bif.rsp_ready = 1'b0;
    bif.prdata    = 32'hC0DE0000;
    setups = 0;
    for (int k = 0; k < 6; k++) begin
      bif.cmd_valid = 1'b1;
      bif.cmd_addr  = 32'h100 + 32'(4 * k);
      bif.cmd_write = k[0];
      bif.cmd_wdata = 32'hA0000000 + 32'(k);
      checks++;
      if (bif.cmd_ready !== exp_rdy[k]) begin
        failures++;
        $display("FAIL bp_cmd_ready[%0d] got=%b exp=%b",
                 k, bif.cmd_ready, exp_rdy[k]);
      end
      tick();
      if (bif.psel === 1'b1 && bif.penable === 1'b0) setups++;
    end
    bif.cmd_valid = 1'b0;
    checks++;
    if (setups !== 1) begin
      failures++;
      $display("FAIL bp_fill_setups got=%0d exp=1", setups);
    end
    checks++;
    if (bif.rsp_valid !== 1'b1 || bif.rsp_write !== 1'b0
        || bif.rsp_rdata !== 32'hC0DE0000) begin
      failures++;
      $display("FAIL bp_first_rsp valid=%b write=%b rdata=%h exp=1,0,c0de0000",
               bif.rsp_valid, bif.rsp_write, bif.rsp_rdata);
    end
    stall_psel = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bif.psel !== 1'b0 || bif.rsp_valid !== 1'b1) stall_psel++;
    end
    checks++;
    if (stall_psel !== 0) begin
      failures++;
      $display("FAIL bp_stall bad_cycles got=%0d exp=0", stall_psel);
    end
    checks++;
    if (bif.cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_full cmd_ready got=%b exp=0", bif.cmd_ready);
    end
    bif.rsp_ready = 1'b1;
    tick();
    for (int k = 1; k < 5; k++) begin
      ea = 32'h100 + 32'(4 * k);
      er = k[0] ? 32'h0 : 32'hC0DE0000 + 32'(k);
      checks++;
      if (bif.psel !== 1'b1 || bif.penable !== 1'b0
          || bif.paddr !== ea || bif.rsp_valid !== 1'b0) begin
        failures++;
        $display("FAIL bp_setup[%0d] psel=%b paddr=%h rsp_valid=%b exp=1,%h,0",
                 k, bif.psel, bif.paddr, bif.rsp_valid, ea);
      end
      bif.prdata = 32'hC0DE0000 + 32'(k);
      tick();
      tick();
      checks++;
      if (bif.rsp_valid !== 1'b1 || bif.rsp_write !== k[0]
          || bif.rsp_rdata !== er) begin
        failures++;
        $display("FAIL bp_rsp[%0d] valid=%b write=%b rdata=%h exp=1,%b,%h",
                 k, bif.rsp_valid, bif.rsp_write, bif.rsp_rdata, k[0], er);
      end
      tick();
    end
    checks++;
    if (bif.busy !== 1'b0 || bif.rsp_valid !== 1'b0
        || bif.psel !== 1'b0) begin
      failures++;
      $display("FAIL bp_end busy=%b rsp_valid=%b psel=%b exp=0,0,0",
               bif.busy, bif.rsp_valid, bif.psel);
    end
    bif.prdata = 32'hBAD0BAD0;
  endtask

  task automatic test_reset_mid();
    int stray;
    bif.rsp_ready = 1'b1;
    bif.cmd_valid = 1'b1;
    bif.cmd_addr  = 32'h30;
    bif.cmd_write = 1'b1;
    bif.cmd_wdata = 32'h77;
    tick();
    bif.cmd_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (bif.penable !== 1'b1) begin
      failures++;
      $display("FAIL rm_access penable=%b exp=1", bif.penable);
    end
    rst = 1'b1;
    bif.cmd_valid = 1'b1;
    bif.cmd_addr  = 32'h34;
    tick();
    checks++;
    if (bif.psel !== 1'b0 || bif.penable !== 1'b0
        || bif.rsp_valid !== 1'b0 || bif.cmd_ready !== 1'b1
        || bif.busy !== 1'b0) begin
      failures++;
      $display("FAIL rm_after psel=%b pen=%b rv=%b crdy=%b busy=%b exp=0,0,0,1,0",
               bif.psel, bif.penable, bif.rsp_valid,
               bif.cmd_ready, bif.busy);
    end
    rst = 1'b0;
    bif.cmd_valid = 1'b0;
    stray = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bif.rsp_valid !== 1'b0 || bif.psel !== 1'b0) stray++;
    end
    checks++;
    if (stray !== 0) begin
      failures++;
      $display("FAIL rm_no_rsp stray_cycles got=%0d exp=0", stray);
    end
  endtask

  task automatic test_back_to_back();
    int nrsp;
    bif.rsp_ready = 1'b1;
    bif.cmd_valid = 1'b1;
    bif.cmd_addr  = 32'h40;
    bif.cmd_write = 1'b0;
    tick();
    bif.cmd_addr  = 32'h44;
    tick();
    bif.cmd_valid = 1'b0;
    bif.prdata = 32'h11110040;
    nrsp = 0;
    for (int j = 2; j < 9; j++) begin
      tick();
      if (bif.rsp_valid === 1'b1) nrsp++;
      checks++;
      if (bif.rsp_valid !== (j == 3 || j == 6)) begin
        failures++;
        $display("FAIL b2b_valid[%0d] got=%b exp=%b",
                 j, bif.rsp_valid, (j == 3 || j == 6));
      end
      if (j == 3) begin
        checks++;
        if (bif.rsp_rdata !== 32'h11110040) begin
          failures++;
          $display("FAIL b2b_rdata0 got=%h exp=11110040", bif.rsp_rdata);
        end
      end
      if (j == 4) begin
        checks++;
        if (bif.paddr !== 32'h44 || bif.psel !== 1'b1) begin
          failures++;
          $display("FAIL b2b_setup1 paddr=%h psel=%b exp=44,1",
                   bif.paddr, bif.psel);
        end
        bif.prdata = 32'h22220044;
      end
      if (j == 6) begin
        checks++;
        if (bif.rsp_rdata !== 32'h22220044) begin
          failures++;
          $display("FAIL b2b_rdata1 got=%h exp=22220044", bif.rsp_rdata);
        end
      end
    end
    checks++;
    if (nrsp !== 2) begin
      failures++;
      $display("FAIL b2b_count got=%0d exp=2", nrsp);
    end
    bif.prdata = 32'hBAD0BAD0;
  endtask

`ifdef APB_PREADY_EN
  task automatic test_pready();
    int hi;
    bif.rsp_ready = 1'b1;
    bif.cmd_valid = 1'b1;
    bif.cmd_addr  = 32'h80;
    bif.cmd_write = 1'b0;
    tick();
    bif.cmd_valid = 1'b0;
    tick();
    bif.pready = 1'b0;
    bif.prdata = 32'h55AA55AA;
    hi = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bif.penable === 1'b1 && bif.rsp_valid === 1'b0) hi++;
    end
    checks++;
    if (hi !== 4) begin
      failures++;
      $display("FAIL pr_wait_cycles got=%0d exp=4", hi);
    end
    bif.pready = 1'b1;
    tick();
    checks++;
    if (bif.penable !== 1'b0 || bif.rsp_valid !== 1'b1
        || bif.rsp_err !== 1'b0 || bif.rsp_rdata !== 32'h55AA55AA) begin
      failures++;
      $display("FAIL pr_done pen=%b rv=%b err=%b rdata=%h exp=0,1,0,55aa55aa",
               bif.penable, bif.rsp_valid, bif.rsp_err, bif.rsp_rdata);
    end
    tick();
  endtask

  task automatic test_timeout();
    int hi;
    bif.rsp_ready = 1'b1;
    bif.cmd_valid = 1'b1;
    bif.cmd_addr  = 32'h84;
    bif.cmd_write = 1'b0;
    tick();
    bif.cmd_valid = 1'b0;
    tick();
    bif.pready = 1'b0;
    bif.prdata = 32'h99999999;
    hi = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (bif.penable === 1'b1 && bif.rsp_valid === 1'b0) hi++;
    end
    checks++;
    if (hi !== 16) begin
      failures++;
      $display("FAIL to_access_cycles got=%0d exp=16", hi);
    end
    tick();
    checks++;
    if (bif.penable !== 1'b0 || bif.rsp_valid !== 1'b1
        || bif.rsp_err !== 1'b1 || bif.rsp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL to_done pen=%b rv=%b err=%b rdata=%h exp=0,1,1,0",
               bif.penable, bif.rsp_valid, bif.rsp_err, bif.rsp_rdata);
    end
    bif.pready = 1'b1;
    tick();
    checks++;
    if (bif.busy !== 1'b0) begin
      failures++;
      $display("FAIL to_idle busy=%b exp=0", bif.busy);
    end
  endtask
`endif

  initial begin
    rst           = 1'b1;
    bif.cmd_valid = 1'b0;
    bif.cmd_addr  = 32'h0;
    bif.cmd_write = 1'b0;
    bif.cmd_wdata = 32'h0;
    bif.rsp_ready = 1'b1;
    bif.prdata    = 32'hBAD0BAD0;
`ifdef APB_PREADY_EN
    bif.pready    = 1'b1;
`endif
    test_reset();
    test_write();
    test_read();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
`ifdef APB_PREADY_EN
    test_pready();
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
